// File: rtl/simplebus_mem_slave.sv
// SimpleBus memory responder: 64-bit word memory with single/burst reads and writes,
// byte masks and a programmable idle gap before the first response beat.
module simplebus_mem_slave #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    output logic        req_ready,
    input  logic        req_valid,
    input  logic [31:0] req_bits_addr,
    input  logic [2:0]  req_bits_size,
    input  logic [3:0]  req_bits_cmd,
    input  logic [7:0]  req_bits_wmask,
    input  logic [63:0] req_bits_wdata,
    input  logic [15:0] req_bits_user,
    input  logic        resp_ready,
    output logic        resp_valid,
    output logic [3:0]  resp_bits_cmd,
    output logic [63:0] resp_bits_rdata,
    output logic [15:0] resp_bits_user
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT4 = 4'(LATENCY);

    localparam logic [3:0] CMD_READ   = 4'b0000;
    localparam logic [3:0] CMD_WRITE  = 4'b0001;
    localparam logic [3:0] CMD_RBURST = 4'b0010;
    localparam logic [3:0] CMD_WBURST = 4'b0011;
    localparam logic [3:0] CMD_WLAST  = 4'b0111;
    localparam logic [3:0] RSP_RBEAT  = 4'b0000;
    localparam logic [3:0] RSP_RLAST  = 4'b0110;
    localparam logic [3:0] RSP_WRESP  = 4'b0101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WBURST,
        S_WAIT,
        S_RRESP,
        S_WRESP
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  widx_q, widx_d;
    logic [15:0]       user_q, user_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [2:0]        beat_q, beat_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              resp_valid_q, resp_valid_d;
    logic [3:0]        resp_cmd_q, resp_cmd_d;
    logic [63:0]       resp_rdata_q, resp_rdata_d;
    logic [15:0]       resp_user_q, resp_user_d;

    logic [63:0]       mem [DEPTH_WORDS];
    logic              mem_we;
    logic [IDX_W-1:0]  mem_widx;
    logic [63:0]       byte_mask;

    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  next_idx;
    logic [2:0]        next_off;
    logic              req_fire;
    logic              resp_fire;
    logic              is_read;
    logic              unused_bits;

    assign unused_bits = ^{req_bits_size, req_bits_addr[31:IDX_W+3], req_bits_addr[2:0]};

    assign req_idx   = req_bits_addr[IDX_W+2:3];
    // Next word inside the 64-byte line, wrapping on the low three index bits.
    assign next_off  = widx_q[2:0] + beat_q + 3'd1;
    assign next_idx  = {widx_q[IDX_W-1:3], next_off};
    assign req_ready = (state_q == S_IDLE) || (state_q == S_WBURST);
    assign req_fire  = req_valid && req_ready;
    assign resp_fire = resp_valid_q && resp_ready;
    assign is_read   = (cmd_q == CMD_READ) || (cmd_q == CMD_RBURST);

    always_comb begin
        byte_mask = '0;
        for (int i = 0; i < 8; i++) begin
            byte_mask[8*i +: 8] = {8{req_bits_wmask[i]}};
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= (mem[mem_widx] & ~byte_mask) | (req_bits_wdata & byte_mask);
        end
    end

    always_comb begin
        state_d      = state_q;
        widx_d       = widx_q;
        user_d       = user_q;
        cmd_d        = cmd_q;
        beat_d       = beat_q;
        cnt_d        = cnt_q;
        resp_valid_d = resp_valid_q;
        resp_cmd_d   = resp_cmd_q;
        resp_rdata_d = resp_rdata_q;
        resp_user_d  = resp_user_q;
        mem_we       = 1'b0;
        mem_widx     = req_idx;

        case (state_q)
            S_IDLE: begin
                if (req_fire) begin
                    widx_d = req_idx;
                    user_d = req_bits_user;
                    cmd_d  = req_bits_cmd;
                    beat_d = 3'd0;
                    cnt_d  = LAT4;
                    mem_we = (req_bits_cmd == CMD_WRITE) || (req_bits_cmd == CMD_WBURST);
                    state_d = (req_bits_cmd == CMD_WBURST) ? S_WBURST : S_WAIT;
                end
            end
            S_WBURST: begin
                if (req_fire) begin
                    mem_we   = 1'b1;
                    mem_widx = next_idx;
                    beat_d   = beat_q + 3'd1;
                    if ((req_bits_cmd == CMD_WLAST) || (beat_q == 3'd6)) begin
                        cnt_d   = LAT4;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    beat_d       = 3'd0;
                    resp_valid_d = 1'b1;
                    resp_user_d  = user_q;
                    if (is_read) begin
                        state_d      = S_RRESP;
                        resp_cmd_d   = (cmd_q == CMD_RBURST) ? RSP_RBEAT : RSP_RLAST;
                        resp_rdata_d = mem[widx_q];
                    end else begin
                        state_d      = S_WRESP;
                        resp_cmd_d   = RSP_WRESP;
                        resp_rdata_d = 64'd0;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RRESP: begin
                if (resp_fire) begin
                    if ((cmd_q != CMD_RBURST) || (beat_q == 3'd7)) begin
                        state_d      = S_IDLE;
                        resp_valid_d = 1'b0;
                    end else begin
                        beat_d       = beat_q + 3'd1;
                        resp_rdata_d = mem[next_idx];
                        resp_cmd_d   = (beat_q == 3'd6) ? RSP_RLAST : RSP_RBEAT;
                    end
                end
            end
            S_WRESP: begin
                if (resp_fire) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d      = S_IDLE;
                resp_valid_d = 1'b0;
            end
        endcase

        // Abort dominates every handshake; writes already committed stay in memory.
        if (flush) begin
            state_d      = S_IDLE;
            resp_valid_d = 1'b0;
            mem_we       = 1'b0;
            beat_d       = 3'd0;
            cnt_d        = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            widx_q       <= '0;
            user_q       <= '0;
            cmd_q        <= '0;
            beat_q       <= '0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_cmd_q   <= '0;
            resp_rdata_q <= '0;
            resp_user_q  <= '0;
        end else begin
            state_q      <= state_d;
            widx_q       <= widx_d;
            user_q       <= user_d;
            cmd_q        <= cmd_d;
            beat_q       <= beat_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_cmd_q   <= resp_cmd_d;
            resp_rdata_q <= resp_rdata_d;
            resp_user_q  <= resp_user_d;
        end
    end

    assign resp_valid      = resp_valid_q;
    assign resp_bits_cmd   = resp_cmd_q;
    assign resp_bits_rdata = resp_rdata_q;
    assign resp_bits_user  = resp_user_q;

endmodule

// File: tb/tb_simplebus_mem_slave.sv
// Bench for simplebus_mem_slave: directed scenarios plus randomized traffic scored
// against a transaction-level memory model covering words 0..63 (addresses alias above).
module tb_simplebus_mem_slave;

    localparam int LAT = 2;
    localparam logic [3:0] C_READ   = 4'b0000;
    localparam logic [3:0] C_WRITE  = 4'b0001;
    localparam logic [3:0] C_RBURST = 4'b0010;
    localparam logic [3:0] C_WBURST = 4'b0011;
    localparam logic [3:0] C_WLAST  = 4'b0111;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        req_ready;
    logic        req_valid;
    logic [31:0] req_bits_addr;
    logic [2:0]  req_bits_size;
    logic [3:0]  req_bits_cmd;
    logic [7:0]  req_bits_wmask;
    logic [63:0] req_bits_wdata;
    logic [15:0] req_bits_user;
    logic        resp_ready;
    logic        resp_valid;
    logic [3:0]  resp_bits_cmd;
    logic [63:0] resp_bits_rdata;
    logic [15:0] resp_bits_user;

    always #5 clk = ~clk;

    simplebus_mem_slave #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_ready(req_ready), .req_valid(req_valid),
        .req_bits_addr(req_bits_addr), .req_bits_size(req_bits_size),
        .req_bits_cmd(req_bits_cmd), .req_bits_wmask(req_bits_wmask),
        .req_bits_wdata(req_bits_wdata), .req_bits_user(req_bits_user),
        .resp_ready(resp_ready), .resp_valid(resp_valid),
        .resp_bits_cmd(resp_bits_cmd), .resp_bits_rdata(resp_bits_rdata),
        .resp_bits_user(resp_bits_user)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] mdl [64];
    logic [3:0]  e_cmd [8];
    logic [63:0] e_dat [8];
    int          e_n;
    logic [15:0] e_usr;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = $urandom;
        a[12:9] = 4'd0;
        return a;
    endfunction

    function automatic int burst_word(input logic [31:0] a, input int k);
        return int'(a[8:6]) * 8 + (int'(a[5:3]) + k) % 8;
    endfunction

    task automatic mdl_write(input int idx, input logic [7:0] m, input logic [63:0] d);
        for (int i = 0; i < 8; i++) begin
            if (m[i]) mdl[idx][8*i +: 8] = d[8*i +: 8];
        end
    endtask

    // Called at a negedge; returns just after the accepting posedge.
    task automatic send(input logic [31:0] a, input logic [3:0] c, input logic [7:0] m,
                        input logic [63:0] d, input logic [15:0] u);
        int w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("req_ready", 64'(req_ready), 64'd1);
        req_bits_addr  = a;
        req_bits_cmd   = c;
        req_bits_wmask = m;
        req_bits_wdata = d;
        req_bits_user  = u;
        req_bits_size  = 3'(($urandom) & 7);
        req_valid      = 1'b1;
        @(posedge clk);
    endtask

    // mode 0: ready held high; 1: random ready; 2: hold ready low 5 cycles on beat bp_beat.
    task automatic collect(input int mode, input int bp_beat);
        int n = 0;
        int k = 0;
        int stall = 0;
        int guard = 0;
        logic r;
        @(negedge clk);
        req_valid = 1'b0;
        chk("busy_after_req", 64'(req_ready), 64'd0);
        while (!resp_valid && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("latency", 64'(n), 64'(LAT + 1));
        while (k < e_n) begin
            chk($sformatf("valid[%0d]", k), 64'(resp_valid), 64'd1);
            chk($sformatf("cmd[%0d]", k), 64'(resp_bits_cmd), 64'(e_cmd[k]));
            chk($sformatf("rdata[%0d]", k), resp_bits_rdata, e_dat[k]);
            chk($sformatf("user[%0d]", k), 64'(resp_bits_user), 64'(e_usr));
            guard++;
            if (mode == 1) r = (guard > 60) ? 1'b1 : 1'($urandom_range(0, 1));
            else if (mode == 2) r = !(k == bp_beat && stall < 5);
            else r = 1'b1;
            if (!r) stall++;
            resp_ready = r;
            @(posedge clk);
            if (r) k++;
            @(negedge clk);
        end
        resp_ready = 1'b0;
        chk("end_valid", 64'(resp_valid), 64'd0);
        chk("end_req_ready", 64'(req_ready), 64'd1);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [7:0] m, input logic [63:0] d,
                            input logic [15:0] u);
        send(a, C_WRITE, m, d, u);
        mdl_write(int'(a[8:3]), m, d);
        e_n = 1; e_cmd[0] = 4'b0101; e_dat[0] = 64'd0; e_usr = u;
        collect(1, 0);
    endtask

    task automatic do_read(input logic [31:0] a, input bit burst, input logic [15:0] u,
                           input int mode, input int bpb);
        send(a, burst ? C_RBURST : C_READ, 8'($urandom), {$urandom, $urandom}, u);
        e_usr = u;
        if (burst) begin
            e_n = 8;
            for (int k = 0; k < 8; k++) begin
                e_cmd[k] = (k == 7) ? 4'b0110 : 4'b0000;
                e_dat[k] = mdl[burst_word(a, k)];
            end
        end else begin
            e_n = 1; e_cmd[0] = 4'b0110; e_dat[0] = mdl[int'(a[8:3])];
        end
        collect(mode, bpb);
    endtask

    task automatic do_wburst(input logic [31:0] a, input int nb, input bit lastf,
                             input logic [15:0] u, input bit full, input bit seq);
        logic [63:0] d;
        logic [7:0]  m;
        logic [3:0]  c;
        for (int i = 0; i < nb; i++) begin
            if (i > 0) @(negedge clk);
            d = seq ? 64'(i) : {$urandom, $urandom};
            m = full ? 8'hFF : 8'($urandom);
            c = (i == 0) ? C_WBURST : ((i == nb - 1 && lastf) ? C_WLAST : C_WBURST);
            send((i == 0) ? a : $urandom, c, m, d, u);
            mdl_write(burst_word(a, i), m, d);
        end
        e_n = 1; e_cmd[0] = 4'b0101; e_dat[0] = 64'd0; e_usr = u;
        collect(1, 0);
    endtask

    task automatic do_other(input logic [31:0] a, input logic [15:0] u);
        send(a, 4'($urandom_range(4, 15)), 8'hFF, {$urandom, $urandom}, u);
        e_n = 1; e_cmd[0] = 4'b0101; e_dat[0] = 64'd0; e_usr = u;
        collect(1, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [15:0] u;
        int kind;
        int n;
        int nb;

        rst = 1'b0; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        req_bits_addr = '0; req_bits_size = '0; req_bits_cmd = '0;
        req_bits_wmask = '0; req_bits_wdata = '0; req_bits_user = '0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_cmd", 64'(resp_bits_cmd), 64'd0);
        chk("rst_resp_rdata", resp_bits_rdata, 64'd0);
        chk("rst_resp_user", 64'(resp_bits_user), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Fill the modelled region with full-mask bursts so every word is known.
        for (int l = 0; l < 8; l++) begin
            do_wburst(32'(l * 64), 8, 1'($urandom_range(0, 1)), 16'($urandom), 1'b1, 1'b0);
        end

        // Single write then read.
        do_write(32'h80000010, 8'hFF, 64'h1122334455667788, 16'h00A5);
        send(32'h80000010, C_READ, 8'h00, 64'd0, 16'h005A);
        e_n = 1; e_cmd[0] = 4'b0110; e_dat[0] = 64'h1122334455667788; e_usr = 16'h005A;
        collect(0, 0);

        // Byte mask over a zero word.
        do_write(32'h00000040, 8'hFF, 64'd0, 16'h0001);
        do_write(32'h00000040, 8'h0F, 64'hFFFFFFFFFFFFFFFF, 16'h0002);
        send(32'h00000040, C_READ, 8'h00, 64'd0, 16'h0003);
        e_n = 1; e_cmd[0] = 4'b0110; e_dat[0] = 64'h00000000FFFFFFFF; e_usr = 16'h0003;
        collect(0, 0);

        // Burst write 0..7 at 0x100, then wrapped burst read from 0x128.
        do_wburst(32'h00000100, 8, 1'b1, 16'h0B0B, 1'b1, 1'b1);
        send(32'h00000128, C_RBURST, 8'h00, 64'd0, 16'h0C0C);
        e_n = 8; e_usr = 16'h0C0C;
        for (int k = 0; k < 8; k++) begin
            e_cmd[k] = (k == 7) ? 4'b0110 : 4'b0000;
            e_dat[k] = 64'((5 + k) % 8);
        end
        collect(0, 0);

        // Backpressure on beat 3, then early-terminated and auto-terminated bursts.
        do_read(32'h00000100, 1'b1, 16'h0D0D, 2, 3);
        do_wburst(32'h00000188, 3, 1'b1, 16'h0E0E, 1'b0, 1'b0);
        do_read(32'h00000180, 1'b1, 16'h0E0F, 0, 0);
        do_wburst(32'h000001F0, 8, 1'b0, 16'h0F0F, 1'b0, 1'b0);
        do_read(32'h000001C0, 1'b1, 16'h0F10, 0, 0);

        // Flush after beat 2 of a burst read.
        send(32'h00000110, C_RBURST, 8'h00, 64'd0, 16'h1111);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("fl_rdata[%0d]", k), resp_bits_rdata, mdl[burst_word(32'h110, k)]);
            resp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        resp_ready = 1'b0;
        chk("flush_valid", 64'(resp_valid), 64'd0);
        chk("flush_req_ready", 64'(req_ready), 64'd1);
        do_read(32'h00000118, 1'b0, 16'h1212, 0, 0);

        // Flush in IDLE drops a simultaneous write request.
        req_bits_addr = 32'h00000020; req_bits_cmd = C_WRITE; req_bits_wmask = 8'hFF;
        req_bits_wdata = 64'hDEADBEEFDEADBEEF; req_bits_user = 16'h1313;
        req_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        chk("flush_drop_valid", 64'(resp_valid), 64'd0);
        chk("flush_drop_ready", 64'(req_ready), 64'd1);
        do_read(32'h00000020, 1'b0, 16'h1414, 0, 0);

        // Asynchronous reset during WAIT.
        send(32'h80000010, C_READ, 8'h00, 64'd0, 16'h1515);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rstw_valid", 64'(resp_valid), 64'd0);
        chk("rstw_req_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rstw_quiet", 64'(resp_valid), 64'd0);
        end
        do_read(32'h80000010, 1'b0, 16'h1616, 0, 0);

        // Randomized traffic against the model.
        for (int t = 0; t < 60; t++) begin
            kind = $urandom_range(0, 4);
            a = rnd_addr();
            u = 16'($urandom);
            case (kind)
                0: do_write(a, 8'($urandom), {$urandom, $urandom}, u);
                1: do_read(a, 1'b0, u, int'($urandom_range(0, 1)), 0);
                2: do_read(a, 1'b1, u, int'($urandom_range(0, 1)), 0);
                3: begin
                    nb = $urandom_range(2, 8);
                    do_wburst(a, nb, (nb < 8) ? 1'b1 : 1'($urandom_range(0, 1)), u, 1'b0, 1'b0);
                end
                default: do_other(a, u);
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
